// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and pipe_hazard_ctrl.
// master = datapath side (drives hazard inputs), slave = controller side.
interface pipe_hazard_ctrl_if;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic [4:0]  ex_rd;
  logic        ex_mem_read;
  logic        ex_branch_taken;
  logic        mem_req;
  logic        mem_ready;
  logic        dbg_halt;
  logic        dbg_resume;
  logic        pc_stall;
  logic        if_id_stall;
  logic        id_ex_stall;
  logic        ex_mem_stall;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        mem_wb_flush;
  logic        mem_timeout;
  logic        halted;
  logic [31:0] stall_cycles;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, mem_req, mem_ready, dbg_halt, dbg_resume,
    input  pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush,
           id_ex_flush, mem_wb_flush, mem_timeout, halted, stall_cycles
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, mem_req, mem_ready, dbg_halt, dbg_resume,
    output pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush,
           id_ex_flush, mem_wb_flush, mem_timeout, halted, stall_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, memory-wait freeze with timeout, debug halt.
// Optional STALL_CNT_EN macro enables the saturating pc_stall cycle counter on stall_cycles.
module pipe_hazard_ctrl (
  input  logic               clk,
  input  logic               rst_n,
  pipe_hazard_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_e;

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;

  logic load_use;
  logic freeze;
  logic run_rules;
  logic pc_st, if_id_st, id_ex_fl, if_id_fl, tmo, hlt;

  assign load_use = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                    ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                     (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    freeze    = 1'b0;
    run_rules = 1'b0;
    tmo       = 1'b0;
    hlt       = 1'b0;
    unique case (state_q)
      RUN: begin
        if (bus.dbg_halt) begin
          freeze  = 1'b1;
          state_d = HALT;
        end else if (bus.mem_req && !bus.mem_ready) begin
          freeze  = 1'b1;
          state_d = MEM_WAIT;
          wait_d  = '0;
        end else begin
          run_rules = 1'b1;
        end
      end
      MEM_WAIT: begin
        // dbg_halt is deliberately not looked at here; RUN picks it up afterwards
        if (bus.mem_ready) begin
          run_rules = 1'b1;
          state_d   = RUN;
        end else if (wait_q == '1) begin
          tmo     = 1'b1;
          state_d = RUN;
        end else begin
          freeze = 1'b1;
          wait_d = wait_q + 8'd1;
        end
      end
      HALT: begin
        freeze = 1'b1;
        hlt    = 1'b1;
        if (bus.dbg_resume) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Branch outranks load-use: a taken branch flushes and never stalls.
  always_comb begin
    pc_st    = freeze || (run_rules && !bus.ex_branch_taken && load_use);
    if_id_st = pc_st;
    if_id_fl = run_rules && bus.ex_branch_taken;
    id_ex_fl = run_rules && (bus.ex_branch_taken || load_use);
  end

  assign bus.pc_stall     = rst_n && pc_st;
  assign bus.if_id_stall  = rst_n && if_id_st;
  assign bus.id_ex_stall  = rst_n && freeze;
  assign bus.ex_mem_stall = rst_n && freeze;
  assign bus.if_id_flush  = rst_n && if_id_fl;
  assign bus.id_ex_flush  = rst_n && id_ex_fl;
  assign bus.mem_wb_flush = rst_n && freeze;
  assign bus.mem_timeout  = rst_n && tmo;
  assign bus.halted       = rst_n && hlt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (pc_st && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.stall_cycles = stall_cnt_q;
`else
  assign bus.stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table, directed multi-cycle sequences,
// and randomized traffic against a rule-level reference model.
module tb_pipe_hazard_ctrl;

  logic clk;
  logic rst_n;

  pipe_hazard_ctrl_if hz();

  pipe_hazard_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_st, if_id_st, id_ex_st, ex_mem_st, if_id_fl, id_ex_fl, mem_wb_fl, timeout, halted}
  localparam logic [8:0] O_NONE   = 9'b0000_000_0_0;
  localparam logic [8:0] O_FREEZE = 9'b1111_001_0_0;
  localparam logic [8:0] O_HALTED = 9'b1111_001_0_1;
  localparam logic [8:0] O_LU     = 9'b1100_010_0_0;
  localparam logic [8:0] O_BR     = 9'b0000_110_0_0;
  localparam logic [8:0] O_TMO    = 9'b0000_000_1_0;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: 0 = running, 1 = waiting on memory, 2 = halted
  int     m_mode;
  int     m_waited;
  longint m_stalls;

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2, rd;
    logic       use1, use2, mread, br;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [8:0] dut_out();
    return {hz.pc_stall, hz.if_id_stall, hz.id_ex_stall, hz.ex_mem_stall,
            hz.if_id_flush, hz.id_ex_flush, hz.mem_wb_flush, hz.mem_timeout, hz.halted};
  endfunction

  function automatic logic [8:0] model_out();
    bit hazard_dep, redirect;
    logic [8:0] pipe_rule;
    hazard_dep = hz.ex_mem_read && (hz.ex_rd != 0) &&
                 ((hz.id_use_rs1 && hz.id_rs1 == hz.ex_rd) ||
                  (hz.id_use_rs2 && hz.id_rs2 == hz.ex_rd));
    redirect  = hz.ex_branch_taken;
    pipe_rule = redirect ? O_BR : (hazard_dep ? O_LU : O_NONE);
    if (m_mode == 2) return O_HALTED;
    if (m_mode == 1) begin
      if (hz.mem_ready) return pipe_rule;
      return (m_waited == 255) ? O_TMO : O_FREEZE;
    end
    if (hz.dbg_halt || (hz.mem_req && !hz.mem_ready)) return O_FREEZE;
    return pipe_rule;
  endfunction

  task automatic model_step();
    logic [8:0] o;
    o = model_out();
    if (o[8] && m_stalls < 64'hFFFF_FFFF) m_stalls++;
    if (m_mode == 0) begin
      if (hz.dbg_halt) m_mode = 2;
      else if (hz.mem_req && !hz.mem_ready) begin
        m_mode   = 1;
        m_waited = 0;
      end
    end else if (m_mode == 1) begin
      if (hz.mem_ready || m_waited == 255) m_mode = 0;
      else m_waited++;
    end else if (hz.dbg_resume) begin
      m_mode = 0;
    end
  endtask

  task automatic model_reset();
    m_mode   = 0;
    m_waited = 0;
    m_stalls = 0;
  endtask

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_stalls();
`ifdef STALL_CNT_EN
    return m_stalls[31:0];
`else
    return 32'd0;
`endif
  endfunction

  task automatic set_idle();
    hz.id_rs1 = '0; hz.id_rs2 = '0; hz.id_use_rs1 = 0; hz.id_use_rs2 = 0;
    hz.ex_rd = '0; hz.ex_mem_read = 0; hz.ex_branch_taken = 0;
    hz.mem_req = 0; hz.mem_ready = 0; hz.dbg_halt = 0; hz.dbg_resume = 0;
  endtask

  // Inputs already driven; compare at negedge against the model, then advance one clock.
  task automatic cycle(input string name);
    @(negedge clk);
    check(name, dut_out(), model_out());
    check32({name, "_cnt"}, hz.stall_cycles, exp_stalls());
    model_step();
    @(posedge clk); #1;
  endtask

  // Same, but against a hand-derived constant.
  task automatic exp_step(input string name, input logic [8:0] exp);
    @(negedge clk);
    check(name, dut_out(), exp);
    model_step();
    @(posedge clk); #1;
  endtask

  task automatic async_reset(input string name);
    #2 rst_n = 1'b0;
    #1;
    check({name, "_imm"}, dut_out(), O_NONE);
    check32({name, "_cnt"}, hz.stall_cycles, 32'd0);
    model_reset();
    hz.dbg_halt = 1; hz.mem_req = 1; hz.ex_branch_taken = 1;
    @(negedge clk);
    check({name, "_held"}, dut_out(), O_NONE);
    set_idle();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    tbl.push_back('{"lu_rs1",      5'd5,  5'd0,  5'd5,  1, 0, 1, 0, O_LU});
    tbl.push_back('{"lu_rd0",      5'd5,  5'd0,  5'd0,  1, 0, 1, 0, O_NONE});
    tbl.push_back('{"lu_rd0_rs0",  5'd0,  5'd0,  5'd0,  1, 1, 1, 0, O_NONE});
    tbl.push_back('{"lu_rs2",      5'd1,  5'd17, 5'd17, 0, 1, 1, 0, O_LU});
    tbl.push_back('{"lu_nouse",    5'd9,  5'd9,  5'd9,  0, 0, 1, 0, O_NONE});
    tbl.push_back('{"no_load",     5'd9,  5'd0,  5'd9,  1, 0, 0, 0, O_NONE});
    tbl.push_back('{"br_and_lu",   5'd5,  5'd0,  5'd5,  1, 0, 1, 1, O_BR});
    tbl.push_back('{"br_only",     5'd2,  5'd3,  5'd4,  1, 1, 0, 1, O_BR});
    tbl.push_back('{"rs2_unused",  5'd4,  5'd3,  5'd3,  1, 0, 1, 0, O_NONE});
    tbl.push_back('{"lu_rd31",     5'd31, 5'd0,  5'd31, 1, 0, 1, 0, O_LU});
    tbl.push_back('{"idle",        5'd0,  5'd0,  5'd0,  0, 0, 0, 0, O_NONE});

    set_idle();
    model_reset();
    rst_n = 1'b0;
    hz.dbg_halt = 1; hz.ex_mem_read = 1; hz.ex_rd = 5'd5; hz.id_rs1 = 5'd5; hz.id_use_rs1 = 1;
    #3;
    check("reset_outs", dut_out(), O_NONE);
    check32("reset_cnt", hz.stall_cycles, 32'd0);
    set_idle();
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-cycle RUN-state rules
    foreach (tbl[i]) begin
      hz.id_rs1 = tbl[i].rs1; hz.id_rs2 = tbl[i].rs2; hz.ex_rd = tbl[i].rd;
      hz.id_use_rs1 = tbl[i].use1; hz.id_use_rs2 = tbl[i].use2;
      hz.ex_mem_read = tbl[i].mread; hz.ex_branch_taken = tbl[i].br;
      exp_step(tbl[i].name, tbl[i].exp);
    end
    set_idle();
    cycle("tbl_cnt");

    // Memory wait of 3 cycles, released on the 4th
    begin
      longint s0;
      s0 = m_stalls;
      hz.mem_req = 1;
      for (int i = 0; i < 3; i++) exp_step("mw3_freeze", O_FREEZE);
      hz.mem_ready = 1;
      exp_step("mw3_release", O_NONE);
      set_idle();
      @(negedge clk);
`ifdef STALL_CNT_EN
      check32("mw3_cnt", hz.stall_cycles, 32'(s0 + 3));
`else
      check32("mw3_cnt", hz.stall_cycles, 32'd0);
`endif
      @(posedge clk); #1;
    end
    cycle("mw3_run");

    // Memory wait with a taken branch in the completion cycle
    hz.mem_req = 1;
    exp_step("mwbr_freeze", O_FREEZE);
    hz.mem_ready = 1; hz.ex_branch_taken = 1;
    exp_step("mwbr_release", O_BR);
    set_idle();

    // Held-off memory: 256 frozen cycles, then the timeout pulse
    hz.mem_req = 1;
    for (int i = 0; i < 256; i++) exp_step("to_freeze", O_FREEZE);
    exp_step("to_pulse", O_TMO);
    hz.mem_req = 0;
    exp_step("to_run", O_NONE);

    // dbg_halt ignored during memory wait, taken afterwards in RUN
    hz.mem_req = 1;
    exp_step("mwh_enter", O_FREEZE);
    hz.dbg_halt = 1;
    exp_step("mwh_ignore", O_FREEZE);
    hz.mem_ready = 1;
    exp_step("mwh_done", O_NONE);
    hz.mem_req = 0; hz.mem_ready = 0;
    exp_step("mwh_halt", O_FREEZE);
    hz.dbg_halt = 0;
    exp_step("mwh_halted", O_HALTED);
    hz.dbg_halt = 1; hz.dbg_resume = 1;
    exp_step("mwh_both", O_HALTED);
    hz.dbg_halt = 0; hz.dbg_resume = 0;
    exp_step("mwh_resumed", O_NONE);

    // Halt pulse, hold, resume
    hz.dbg_halt = 1;
    exp_step("h_enter", O_FREEZE);
    hz.dbg_halt = 0;
    for (int i = 0; i < 3; i++) exp_step("h_hold", O_HALTED);
    hz.dbg_resume = 1;
    exp_step("h_resume", O_HALTED);
    hz.dbg_resume = 0;
    exp_step("h_release", O_NONE);

    // Reset mid-HALT and mid-MEM_WAIT
    hz.dbg_halt = 1;
    exp_step("hr_enter", O_FREEZE);
    hz.dbg_halt = 0;
    exp_step("hr_halted", O_HALTED);
    async_reset("rst_halt");
    exp_step("rst_halt_run", O_NONE);
    hz.mem_req = 1;
    for (int i = 0; i < 4; i++) exp_step("mr_freeze", O_FREEZE);
    async_reset("rst_wait");
    exp_step("rst_wait_run", O_NONE);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      hz.id_rs1          = 5'($urandom_range(0, 3));
      hz.id_rs2          = 5'($urandom_range(0, 3));
      hz.ex_rd           = 5'($urandom_range(0, 3));
      hz.id_use_rs1      = 1'($urandom_range(0, 1));
      hz.id_use_rs2      = 1'($urandom_range(0, 1));
      hz.ex_mem_read     = 1'($urandom_range(0, 1));
      hz.ex_branch_taken = ($urandom_range(0, 3) == 0);
      hz.mem_req         = ($urandom_range(0, 2) == 0);
      hz.mem_ready       = (n >= 1500 && n < 1800) ? 1'b0 : ($urandom_range(0, 3) != 0);
      hz.dbg_halt        = ($urandom_range(0, 15) == 0);
      hz.dbg_resume      = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 299) == 0) async_reset("rand_rst");
      else cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
